// File: rtl/add_tree_sched.sv
// Round-robin scheduler sharing one pipelined saturating adder tree between NUM_CH channels.
// Tracks the owning channel alongside the tree latency and returns each result to its requester.
module add_tree_sched #(
    parameter int DATA_WIDTH = 6,
    parameter int NUM_TAPS   = 8,
    parameter int NUM_CH     = 4,
    parameter int TREE_LAT   = 2,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int INF_W     = $clog2(TREE_LAT + 3)
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [NUM_CH-1:0]                                req_valid,
    input  logic signed [NUM_CH-1:0][NUM_TAPS-1:0][DATA_WIDTH-1:0] req_data,
    output logic [NUM_CH-1:0]                                req_ready,
    output logic signed [NUM_TAPS-1:0][DATA_WIDTH-1:0]       tree_in,
    input  logic signed [DATA_WIDTH-1:0]                     tree_out,
    output logic [NUM_CH-1:0]                                rsp_valid,
    output logic signed [DATA_WIDTH-1:0]                     rsp_data,
    output logic [CH_W-1:0]                                  rsp_ch,
    output logic [INF_W-1:0]                                 inflight,
    output logic                                             idle
);

    typedef struct packed {
        logic            valid;
        logic [CH_W-1:0] ch;
    } tag_t;

    tag_t            tags [0:TREE_LAT];
    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] gnt_ch;
    logic [CH_W-1:0] idx;
    logic            gnt_any;
    logic            ret;

    // Search upward from ptr, wrapping; the first pending channel wins.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        req_ready = '0;
        gnt_any   = 1'b0;
        gnt_ch    = '0;
        idx       = '0;
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                idx = CH_W'((int'(ptr) + i) % NUM_CH);
                if (!gnt_any && req_valid[idx]) begin
                    gnt_any        = 1'b1;
                    gnt_ch         = idx;
                    req_ready[idx] = 1'b1;
                end
            end
        end
    end

    assign ret  = |rsp_valid;
    assign idle = (inflight == '0) && (req_valid == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            tree_in   <= '0;
            // NOTE: the tag pipeline is reset so in-flight requests are dropped; it is a few flops, not a RAM.
            for (int k = 0; k <= TREE_LAT; k++) tags[k] <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_ch    <= '0;
            inflight  <= '0;
        end else begin
            if (gnt_any) begin
                ptr     <= (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
                tree_in <= req_data[gnt_ch];
            end
            tags[0] <= '{valid: gnt_any, ch: gnt_ch};
            for (int k = 1; k <= TREE_LAT; k++) tags[k] <= tags[k-1];

            // Last tag stage lines up with tree_out.
            rsp_valid <= tags[TREE_LAT].valid ? (NUM_CH'(1) << tags[TREE_LAT].ch) : '0;
            rsp_data  <= tree_out;
            rsp_ch    <= tags[TREE_LAT].ch;

            if (gnt_any && !ret)      inflight <= inflight + 1'b1;
            else if (!gnt_any && ret) inflight <= inflight - 1'b1;
        end
    end

endmodule

// File: tb/tb_add_tree_sched.sv
// Bench for add_tree_sched with an attached 2-stage saturating 8-tap tree.
// A queue-based model predicts grants, responses, inflight and idle every cycle.
module tb_add_tree_sched;

    localparam int DW = 6;
    localparam int NT = 8;
    localparam int NC = 4;
    localparam int TL = 2;

    logic                              clk = 1'b0;
    logic                              rst;
    logic [NC-1:0]                     req_valid;
    logic signed [NC-1:0][NT-1:0][DW-1:0] req_data;
    logic [NC-1:0]                     req_ready;
    logic signed [NT-1:0][DW-1:0]      tree_in;
    logic signed [DW-1:0]              tree_out;
    logic [NC-1:0]                     rsp_valid;
    logic signed [DW-1:0]              rsp_data;
    logic [1:0]                        rsp_ch;
    logic [2:0]                        inflight;
    logic                              idle;

    add_tree_sched #(.DATA_WIDTH(DW), .NUM_TAPS(NT), .NUM_CH(NC), .TREE_LAT(TL)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tree_in(tree_in), .tree_out(tree_out),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ch(rsp_ch),
        .inflight(inflight), .idle(idle)
    );

    always #5 clk = ~clk;

    function automatic int tap_sum(input logic [NT-1:0][DW-1:0] v);
        int s = 0;
        for (int t = 0; t < NT; t++) s += int'($signed(v[t]));
        return s;
    endfunction

    function automatic int sat(input int s);
        if (s > 31) return 31;
        if (s < -32) return -32;
        return s;
    endfunction

    // Attached tree: register raw sum, then register the saturated value.
    logic signed [9:0] s1;
    logic signed [DW-1:0] s2;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= 10'(tap_sum(tree_in));
            s2 <= DW'(sat(int'(s1)));
        end
    end
    assign tree_out = s2;

    typedef struct {
        int ch;
        int val;
        int due;
    } exp_t;

    exp_t q[$];
    int   ptr_m;
    int   edge_n;
    int   n_checks;
    int   n_pass;
    int   infl_peak;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at edge %0d",
                      name, $signed(act), act, $signed(exp), exp, edge_n);
    endtask

    function automatic int model_grant();
        for (int i = 0; i < NC; i++) begin
            int c = (ptr_m + i) % NC;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    // One clock: compare everything at the falling edge, advance the model at the rising edge.
    task automatic tick();
        int g;
        @(negedge clk);
        g = rst ? -1 : model_grant();
        check("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : 32'(1 << g));
        if (q.size() > 0 && q[0].due == edge_n) begin
            check("rsp_valid", 32'(rsp_valid), 32'(1 << q[0].ch));
            check("rsp_ch", 32'(rsp_ch), 32'(q[0].ch));
            check("rsp_data", 32'($signed(rsp_data)), 32'(q[0].val));
        end else begin
            check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
        end
        check("inflight", 32'(inflight), 32'(q.size()));
        check("idle", 32'(idle), 32'((q.size() == 0 && req_valid == '0) ? 1 : 0));
        if (int'(inflight) > infl_peak) infl_peak = int'(inflight);
        @(posedge clk);
        edge_n++;
        if (rst) begin
            q.delete();
            ptr_m = 0;
        end else if (g >= 0) begin
            q.push_back('{ch: g, val: sat(tap_sum(req_data[g])), due: edge_n + TL + 1});
            ptr_m = (g + 1) % NC;
        end
        while (q.size() > 0 && q[0].due < edge_n) void'(q.pop_front());
        #1;
    endtask

    typedef struct {
        int ch;
        int taps[NT];
        int exp_sum;
    } vec_t;

    vec_t vecs[4];
    int   order[$];
    int   first_rsp;
    int   first_acc;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        edge_n   = 0;
        ptr_m    = 0;
        infl_peak = 0;

        vecs[0].ch = 1; vecs[0].taps = '{1, 2, 3, 4, -1, -2, 0, 1};       vecs[0].exp_sum = 8;
        vecs[1].ch = 0; vecs[1].taps = '{31, 31, -32, 0, 0, 0, 0, 1};     vecs[1].exp_sum = 31;
        vecs[2].ch = 3; vecs[2].taps = '{-32, -1, 0, 0, 0, 0, 0, 1};      vecs[2].exp_sum = -32;
        vecs[3].ch = 2; vecs[3].taps = '{-1, -1, -1, -1, -1, -1, -1, -1}; vecs[3].exp_sum = -8;

        // Reset, with all channels requesting during reset.
        rst = 1'b1;
        req_valid = '0;
        req_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        req_valid = 4'hF;
        #1;
        check("ready_in_reset", 32'(req_ready), 32'd0);
        check("tree_in_rst_lo", tree_in[31:0], 32'd0);
        check("tree_in_rst_hi", 32'(tree_in[47:32]), 32'd0);
        check("rsp_data_rst", 32'($signed(rsp_data)), 32'd0);
        check("rsp_ch_rst", 32'(rsp_ch), 32'd0);
        check("rsp_valid_rst", 32'(rsp_valid), 32'd0);
        check("inflight_rst", 32'(inflight), 32'd0);
        tick();
        rst = 1'b0;
        req_valid = '0;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_after_reset", 32'(idle), 32'd1);
        end

        // Single-request vectors with exact latency.
        for (int i = 0; i < 4; i++) begin
            for (int t = 0; t < NT; t++) req_data[vecs[i].ch][t] = DW'(vecs[i].taps[t]);
            req_valid = NC'(1 << vecs[i].ch);
            tick();
            req_valid = '0;
            tick();
            check("vec_early1", 32'(rsp_valid), 32'd0);
            tick();
            check("vec_early2", 32'(rsp_valid), 32'd0);
            tick();
            check("vec_rsp_valid", 32'(rsp_valid), 32'(1 << vecs[i].ch));
            check("vec_rsp_ch", 32'(rsp_ch), 32'(vecs[i].ch));
            check("vec_rsp_data", 32'($signed(rsp_data)), 32'(vecs[i].exp_sum));
        end

        // Saturation on consecutive cycles: ch2 all 5, ch3 all -8.
        for (int t = 0; t < NT; t++) begin
            req_data[2][t] = 6'd5;
            req_data[3][t] = 6'h38;
        end
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        tick();
        tick();
        check("sat_hi_valid", 32'(rsp_valid), 32'b0100);
        check("sat_hi_data", 32'($signed(rsp_data)), 32'd31);
        tick();
        check("sat_lo_valid", 32'(rsp_valid), 32'b1000);
        check("sat_lo_data", 32'($signed(rsp_data)), 32'hFFFF_FFE0);
        tick();

        // Round-robin with all channels requesting.
        infl_peak = 0;
        first_rsp = -1;
        order.delete();
        req_valid = 4'hF;
        first_acc = edge_n + 1;
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < NC; c++)
                for (int t = 0; t < NT; t++) req_data[c][t] = DW'($urandom_range(0, 63));
            #1;
            check("rr_grant", 32'(req_ready), 32'(1 << (i % 4)));
            tick();
            if (rsp_valid != '0) begin
                order.push_back(int'(rsp_ch));
                if (first_rsp < 0) first_rsp = edge_n;
            end
        end
        req_valid = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid != '0) begin
                order.push_back(int'(rsp_ch));
                if (first_rsp < 0) first_rsp = edge_n;
            end
        end
        check("rr_rsp_count", 32'(order.size()), 32'd8);
        for (int i = 0; i < order.size(); i++) check("rr_rsp_order", 32'(order[i]), 32'(i % 4));
        check("rr_lag", 32'(first_rsp - first_acc), 32'd3);
        check("rr_peak", 32'(infl_peak), 32'd4);

        // Pointer wrap: after ch3, ch0 beats ch2.
        req_valid = 4'b1000;
        tick();
        req_valid = 4'b0101;
        #1;
        check("wrap_grant", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b0100;
        #1;
        check("wrap_next", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        repeat (4) tick();

        // Reset mid-flight drops two accepted requests.
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        tick();
        rst = 1'b1;
        req_valid = 4'hF;
        tick();
        rst = 1'b0;
        req_valid = '0;
        check("midrst_inflight", 32'(inflight), 32'd0);
        check("midrst_rsp0", 32'(rsp_valid), 32'd0);
        tick();
        check("midrst_rsp1", 32'(rsp_valid), 32'd0);
        tick();
        check("midrst_rsp2", 32'(rsp_valid), 32'd0);
        for (int t = 0; t < NT; t++) req_data[0][t] = DW'(t - 2);
        req_valid = 4'b1001;
        #1;
        check("midrst_ptr0", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        tick();
        tick();
        check("post_rst_valid", 32'(rsp_valid), 32'b0001);
        check("post_rst_data", 32'($signed(rsp_data)), 32'd12);
        tick();

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            req_valid = NC'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req_valid = '0;
            for (int c = 0; c < NC; c++)
                for (int t = 0; t < NT; t++) req_data[c][t] = DW'($urandom_range(0, 63));
            rst = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0;
        req_valid = '0;
        repeat (6) tick();
        check("final_idle", 32'(idle), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
